cp0_except_ctrl: RTL

- Owns the CP0 register set and sequences exception commit for the 5-stage MIPS core.
- Consumes the memory-stage exception decode (is_except / except_type / except_pc) and applies the architectural side effects: EPC, Cause, Status.EXL and BadVAddr.
- Issues a one-cycle registered pipeline flush with the redirect PC.
- Also runs the Count/Compare timer and services MTC0/MFC0.

---
 rtl/cp0_except_ctrl_pkg.sv | 27 ++
 rtl/cp0_timer.sv | 53 +++++
 rtl/cp0_except_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cp0_except_ctrl_pkg.sv
// rtl/cp0_except_ctrl_pkg.sv - CP0 register numbers, exception codes and FSM state type
package cp0_except_ctrl_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam logic [31:0] EXC_INT  = 32'h0000_0000;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [31:0] EXC_NONE = 32'hffff_ffff;

  localparam logic [31:0] EXCEPT_VEC   = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  typedef enum logic {ST_IDLE, ST_FLUSH} cp0_state_e;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with clock divider and sticky timer interrupt
module cp0_timer
  import cp0_except_ctrl_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we_count,
  input  logic        i_we_compare,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_timer_int
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_div;
  logic        r_timer_int;
  logic        w_tick;

  assign w_tick = (COUNT_DIV == 1) ? 1'b1 : r_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 32'd0;
      r_compare   <= 32'd0;
      r_div       <= 1'b0;
      r_timer_int <= 1'b0;
    end else begin
      if (i_we_count) begin
        r_count <= i_wdata;
        r_div   <= 1'b0;
      end else begin
        r_div <= (COUNT_DIV == 1) ? 1'b0 : ~r_div;
        if (w_tick) r_count <= r_count + 32'd1;
      end
      // a Compare write always beats a same-cycle match
      if (i_we_compare) begin
        r_compare   <= i_wdata;
        r_timer_int <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_timer_int <= 1'b1;
      end
    end
  end

  assign o_count     = r_count;
  assign o_compare   = r_compare;
  assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_except_ctrl.sv
// rtl/cp0_except_ctrl.sv - CP0 register file, exception commit sequencing and pipeline flush
module cp0_except_ctrl
  import cp0_except_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL  = 32'h0000_4220,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        stallM,
  input  logic        is_except,
  input  logic [31:0] except_type,
  input  logic [31:0] except_pc,
  input  logic [31:0] pcM,
  input  logic        is_in_delayslotM,
  input  logic [31:0] bad_vaddrM,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic        flush_all,
  output logic [31:0] redirect_pc,
  output logic        timer_int
);

  cp0_state_e  r_state;
  logic        r_flush;
  logic [31:0] r_redirect;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;

  logic        w_commit;
  logic        w_eret;
  logic        w_mtc0;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_timer_int;

  assign w_commit = (r_state == ST_IDLE) & is_except & ~stallM & (except_type != EXC_NONE);
  assign w_eret   = (except_type == EXC_ERET);
  // MTC0 only lands in IDLE and loses to a same-cycle commit
  assign w_mtc0   = cp0_we & (r_state == ST_IDLE) & ~w_commit;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_we_count   (w_mtc0 && (cp0_waddr == CP0_COUNT)),
    .i_we_compare (w_mtc0 && (cp0_waddr == CP0_COMPARE)),
    .i_wdata      (cp0_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_timer_int  (w_timer_int)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_flush    <= 1'b0;
      r_redirect <= 32'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
      r_im       <= 8'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= 6'd0;
      r_ip_sw    <= 2'd0;
      r_exccode  <= 5'd0;
    end else begin
      r_ip_hw <= {ext_int[5] | w_timer_int, ext_int[4:0]};
      r_flush <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_commit) begin
            r_state    <= ST_FLUSH;
            r_flush    <= 1'b1;
            r_redirect <= except_pc;
            if (w_eret) begin
              r_exl <= 1'b0;
            end else begin
              // nested exceptions keep the original return point
              if (!r_exl) begin
                r_epc <= is_in_delayslotM ? (pcM - 32'd4) : pcM;
                r_bd  <= is_in_delayslotM;
              end
              r_exccode <= except_type[4:0];
              r_exl     <= 1'b1;
              if ((except_type == EXC_ADEL) || (except_type == EXC_ADES)) r_badvaddr <= bad_vaddrM;
            end
          end else if (w_mtc0) begin
            case (cp0_waddr)
              CP0_STATUS: begin
                r_im  <= cp0_wdata[15:8];
                r_exl <= cp0_wdata[1];
                r_ie  <= cp0_wdata[0];
              end
              CP0_CAUSE: r_ip_sw <= cp0_wdata[9:8];
              CP0_EPC:   r_epc   <= cp0_wdata;
              default: ;
            endcase
          end
        end
        ST_FLUSH: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign cp0_status  = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign cp0_cause   = {r_bd, w_timer_int, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};
  assign cp0_epc     = r_epc;
  assign flush_all   = r_flush;
  assign redirect_pc = r_redirect;
  assign timer_int   = w_timer_int;

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = r_badvaddr;
      CP0_COUNT:    cp0_rdata = w_count;
      CP0_COMPARE:  cp0_rdata = w_compare;
      CP0_STATUS:   cp0_rdata = cp0_status;
      CP0_CAUSE:    cp0_rdata = cp0_cause;
      CP0_EPC:      cp0_rdata = r_epc;
      CP0_PRID:     cp0_rdata = PRID_VAL;
      default:      cp0_rdata = 32'd0;
    endcase
  end

endmodule
